// File: rtl/fsqrt_refine_if.sv
// Handshake bundle between the square-root estimator, the refinement stage and
// the downstream consumer.
interface fsqrt_refine_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] seed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        busy;

    modport master (
        output in_valid, x, seed, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  in_valid, x, seed, out_ready,
        output in_ready, out_valid, res, busy
    );
endinterface

// File: rtl/fsqrt_refine.sv
// Newton-Raphson refinement of a coarse binary32 square-root seed:
// y <- (y + m/y)/2 on the mantissa, restoring division at one bit per cycle.
module fsqrt_refine #(
    parameter int ITER = 3,
    parameter int FRAC = 26
) (
    input  logic          clk,
    input  logic          rst,
    fsqrt_refine_if.slave s
);

    localparam int W   = FRAC + 2;   // m, y, q: 2 integer bits + FRAC fraction bits
    localparam int G   = FRAC - 23;  // bits below the binary32 lsb
    localparam int BCW = $clog2(W + 1);
    localparam int ICW = $clog2(ITER + 1);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef enum logic [2:0] {IDLE, DIV, AVG, ROUND, DONE} state_t;

    state_t           state, state_nx;
    logic [BCW-1:0]   bit_cnt;
    logic [ICW-1:0]   iter_cnt;
    logic [31:0]      res_q;

    logic [W-1:0]     m_q, y_q, q_q, n_q;
    logic [W:0]       r_q;
    logic [7:0]       e_q;

    // Nearest-even rounding of y to 24 significant bits; bit 24 flags a carry to 2.0.
    function automatic logic [24:0] round_ne(input logic [W-1:0] v);
        logic [24:0] kept;
        logic        guard, sticky;
        kept   = v[W-1:G];
        guard  = v[G-1];
        sticky = |v[G-2:0];
        return kept + 25'(guard & (sticky | kept[0]));
    endfunction

    logic        accept;
    logic [7:0]  x_exp;
    logic [22:0] x_frac;
    logic        sp_hit;
    logic [31:0] sp_val;
    logic [8:0]  exp_sum;
    logic        e_odd;
    logic [W-1:0] m_in, y_in;

    assign accept  = s.in_valid && s.in_ready;
    assign x_exp   = s.x[30:23];
    assign x_frac  = s.x[22:0];
    // (E + 127) >> 1 is the biased exponent of the root; its lsb marks an odd e.
    assign exp_sum = {1'b0, x_exp} + 9'd127;
    assign e_odd   = exp_sum[0];
    assign m_in    = e_odd ? {1'b1, x_frac, {(G+1){1'b0}}}
                           : {2'b01, x_frac, {G{1'b0}}};
    assign y_in    = {2'b01, s.seed[22:0], {G{1'b0}}};

    always_comb begin
        sp_hit = 1'b1;
        sp_val = QNAN;
        if (x_exp == 8'hFF && x_frac != 23'd0) sp_val = QNAN;
        else if (x_exp == 8'h00 && x_frac == 23'd0) sp_val = s.x;
        else if (x_exp == 8'h00) sp_val = 32'h0000_0000;
        else if (x_exp == 8'hFF) sp_val = s.x[31] ? QNAN : PINF;
        else if (s.x[31]) sp_val = QNAN;
        else sp_hit = 1'b0;
    end

    logic [W:0]   div_t, r_nx;
    logic         div_ge;
    logic [W:0]   avg_sum;
    logic [24:0]  rounded;
    logic [22:0]  frac_out;
    logic [7:0]   exp_out;

    assign div_t    = {r_q[W-1:0], n_q[W-1]};
    assign div_ge   = div_t >= {1'b0, y_q};
    assign r_nx     = div_ge ? div_t - {1'b0, y_q} : div_t;
    assign avg_sum  = {1'b0, y_q} + {1'b0, q_q};
    assign rounded  = round_ne(y_q);
    // Leading one absent means the round carried into 2.0: mantissa is 1.0.
    assign frac_out = rounded[23] ? rounded[22:0] : 23'd0;
    assign exp_out  = e_q + {7'd0, rounded[24]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (s.in_valid) state_nx = sp_hit ? DONE : DIV;
            DIV:   if (bit_cnt == BCW'(W - 1)) state_nx = AVG;
            AVG:   state_nx = (int'(iter_cnt) + 1 < ITER) ? DIV : ROUND;
            ROUND: state_nx = DONE;
            DONE:  if (s.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            iter_cnt <= '0;
            res_q    <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    bit_cnt  <= '0;
                    iter_cnt <= '0;
                    if (sp_hit) res_q <= sp_val;
                end
                DIV:   bit_cnt <= bit_cnt + 1'b1;
                AVG: begin
                    bit_cnt  <= '0;
                    iter_cnt <= iter_cnt + 1'b1;
                end
                ROUND: res_q <= {1'b0, exp_out, frac_out};
                default: ;
            endcase
        end
    end

    // Datapath: division remainder starts at m/4 with m's low two bits still to shift in.
    always_ff @(posedge clk) begin
        unique case (state)
            IDLE: if (s.in_valid) begin
                m_q <= m_in;
                y_q <= y_in;
                e_q <= exp_sum[8:1];
                r_q <= {3'b000, m_in[W-1:2]};
                n_q <= {m_in[1:0], {FRAC{1'b0}}};
            end
            DIV: begin
                r_q <= r_nx;
                n_q <= n_q << 1;
                q_q <= {q_q[W-2:0], div_ge};
            end
            AVG: begin
                y_q <= avg_sum[W:1];
                r_q <= {3'b000, m_q[W-1:2]};
                n_q <= {m_q[1:0], {FRAC{1'b0}}};
            end
            default: ;
        endcase
    end

    assign s.in_ready  = (state == IDLE) && !rst;
    assign s.out_valid = (state == DONE);
    assign s.busy      = (state != IDLE);
    assign s.res       = res_q;

endmodule

// File: tb/tb_fsqrt_refine.sv
// Bench for fsqrt_refine: fixed vectors, reset abort, backpressure and a
// randomized sweep against an integer square-root reference.
module tb_fsqrt_refine;

    localparam int ITER     = 3;
    localparam int FRAC     = 26;
    localparam int NORM_LAT = 1 + ITER * (FRAC + 3) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fsqrt_refine_if bus();

    fsqrt_refine #(.ITER(ITER), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] seed;
        logic [31:0] expv;
        int          tol;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic check_ulp(input string name, input logic [31:0] act, input logic [31:0] expv,
                             input int tol);
        longint d;
        n_checks++;
        d = (act > expv) ? longint'(act - expv) : longint'(expv - act);
        if ($isunknown(act) || d > tol) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h within %0d ulp", name, act, expv, tol);
        end
    endtask

    function automatic longint unsigned isqrt(input longint unsigned v);
        longint unsigned r, t;
        r = 0;
        for (int b = 25; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_sqrt(input logic [31:0] v);
        int              e, half;
        longint unsigned mant, sq, r;
        logic [7:0]      ex;
        logic [22:0]     fr;
        ex = v[30:23];
        fr = v[22:0];
        if (ex == 8'hFF && fr != 0) return 32'h7FC0_0000;
        if (ex == 8'h00 && fr == 0) return v;
        if (ex == 8'h00) return 32'h0000_0000;
        if (ex == 8'hFF) return v[31] ? 32'h7FC0_0000 : 32'h7F80_0000;
        if (v[31]) return 32'h7FC0_0000;
        e    = int'(ex) - 127;
        mant = 64'h80_0000 | longint'(fr);
        if ((e & 1) != 0) begin
            mant = mant << 1;
            e    = e - 1;
        end
        half = e / 2;
        sq   = mant << 23;
        r    = isqrt(sq);
        if (sq > r * r + r) r = r + 1;
        if (r == (64'd1 << 24)) begin
            r    = 64'd1 << 23;
            half = half + 1;
        end
        return {1'b0, 8'(half + 127), r[22:0]};
    endfunction

    function automatic logic [31:0] est_seed(input logic [31:0] v);
        logic [32:0] sum;
        sum = {1'b0, v} + 33'h0_3F80_0000;
        return sum[32:1];
    endfunction

    function automatic bit is_pos_normal(input logic [31:0] v);
        return !v[31] && v[30:23] != 8'h00 && v[30:23] != 8'hFF;
    endfunction

    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] xv, input logic [31:0] sv,
                          output logic [31:0] r, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", bus.in_ready);
            r   = 'x;
            lat = -1;
            return;
        end
        bus.in_valid = 1'b1;
        bus.x        = xv;
        bus.seed     = sv;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_out(lat);
        r = bus.out_valid ? bus.res : 'x;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    vec_t        vecs[15];
    logic [31:0] r, r0, xv;
    int          lat, seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 0, NORM_LAT};
        vecs[1]  = '{32'h3E80_0000, 32'h3F00_0000, 32'h3F00_0000, 0, NORM_LAT};
        vecs[2]  = '{32'h4110_0000, 32'h4050_0000, 32'h4040_0000, 0, NORM_LAT};
        vecs[3]  = '{32'h4000_0000, 32'h3FC0_0000, 32'h3FB5_04F3, 1, NORM_LAT};
        vecs[4]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0, NORM_LAT};
        vecs[5]  = '{32'h4180_0000, 32'h4080_0000, 32'h4080_0000, 0, NORM_LAT};
        vecs[6]  = '{32'h407F_FFFF, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 1, NORM_LAT};
        vecs[7]  = '{32'h40C8_0000, 32'h4024_0000, 32'h4020_0000, 0, NORM_LAT};
        vecs[8]  = '{32'hBF80_0000, 32'h0000_0000, 32'h7FC0_0000, 0, 1};
        vecs[9]  = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 0, 1};
        vecs[10] = '{32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 0, 1};
        vecs[11] = '{32'h7FC0_0001, 32'h0000_0000, 32'h7FC0_0000, 0, 1};
        vecs[12] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 0, 1};
        vecs[13] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 1};
        vecs[14] = '{32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000, 0, 1};

        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.seed      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_res", bus.res, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Fixed vectors
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].x, vecs[i].seed, r, lat);
            check_ulp($sformatf("vec%0d_res", i), r, vecs[i].expv, vecs[i].tol);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Reset in the middle of a division aborts the operation
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x        = 32'h4080_0000;
        bus.seed     = 32'h4000_0000;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy_async", {31'd0, bus.busy}, 32'd0);
        check("abort_in_ready_rst", {31'd0, bus.in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("abort_no_out_valid", 32'(seen), 32'd0);
        run_op(32'h4110_0000, 32'h4050_0000, r, lat);
        check("abort_next_res", r, 32'h4040_0000);
        check("abort_next_lat", 32'(lat), 32'(NORM_LAT));

        // Backpressure: result held, second request waits, then runs in order
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x        = 32'h40C8_0000;
        bus.seed     = est_seed(32'h40C8_0000);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_out(lat);
        r0 = bus.res;
        check("bp_first_res", r0, 32'h4020_0000);
        bus.in_valid = 1'b1;
        bus.x        = 32'h4110_0000;
        bus.seed     = 32'h4050_0000;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_res_%0d", c), bus.res, 32'h4020_0000);
            check($sformatf("bp_hold_in_ready_%0d", c), {30'd0, bus.in_ready, bus.out_valid}, 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check("bp_release", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("bp_second_busy", {31'd0, bus.busy}, 32'd1);
        wait_out(lat);
        check("bp_second_res", bus.out_valid ? bus.res : 32'hxxxx_xxxx, 32'h4040_0000);
        check("bp_second_lat", 32'(lat), 32'(NORM_LAT));
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;

        // Randomized sweep against the reference model
        for (int i = 0; i < 300; i++) begin
            if (i % 10 == 0) xv = $urandom;
            else xv = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            run_op(xv, est_seed(xv), r, lat);
            if (is_pos_normal(xv)) begin
                check_ulp($sformatf("rand%0d_res x=%h", i, xv), r, ref_sqrt(xv), 1);
                check($sformatf("rand%0d_lat", i), 32'(lat), 32'(NORM_LAT));
            end else begin
                check($sformatf("rand%0d_res x=%h", i, xv), r, ref_sqrt(xv));
                check($sformatf("rand%0d_lat", i), 32'(lat), 32'd1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
